fb_rect_writer: RTL and testbench
=================================

// Module: fb_rect_writer
// PURPOSE
//  Write side of the 640x480 background index frame RAM: the VGA display path reads port A, this
//  block drives port B. On a start request it fills a clipped rectangle with one 8-bit colour index,
//  one pixel per cycle, so game logic can erase eaten pellets or redraw maze tiles at run time.
//  Sits between the game-state logic (procClock domain) and the frame RAM write port.
// PARAMETERS
//  H_RES   640  pixels per row; also the row stride of the frame RAM address
//  V_RES   480  rows in the frame
//  AW      19   frame RAM address width
// PORTS
//  procClock   in   1   system clock; all logic on its rising edge
//  rst         in   1   synchronous active-high reset
//  start       in   1   one-cycle request; sampled only while busy==0
//  rect_x      in   10  left column of rectangle
//  rect_y      in   9   top row of rectangle
//  rect_w      in   10  width in pixels
//  rect_h      in   9   height in pixels
//  fill_index  in   8   colour index written to every pixel
//  wr_ready    in   1   frame RAM port B accepts a write this cycle (arbitration stall)
//  wr_en       out  1   write strobe to frame RAM port B
//  wr_addr     out  AW  write address = row*H_RES + col
//  wr_data     out  8   write data (latched fill_index)
//  busy        out  1   high from cycle after accepted start until done
//  done        out  1   one-cycle pulse when rectangle complete (also for empty rectangle)
//  pix_count   out  19  pixels written by last/current operation
// BEHAVIOUR
//  - Reset: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, pix_count=0, FSM=IDLE.
//  - Reset mid-operation aborts immediately: no further writes, no done pulse.
//  - FSM states: IDLE -> SETUP -> FILL -> DONE -> IDLE.
//  - IDLE: start==1 latches rect_*, fill_index; pix_count<=0; go SETUP, busy<=1.
//    start while busy is ignored (not queued).
//  - SETUP (1 cycle): clip: x_end=min(rect_x+rect_w, H_RES), y_end=min(rect_y+rect_h, V_RES)
//    using 11-/10-bit sums (no wrap). If rect_w==0, rect_h==0, rect_x>=H_RES or rect_y>=V_RES:
//    go DONE with zero writes. Else row_base=rect_y*H_RES (shift-add, no multiplier),
//    col=rect_x, row=rect_y; go FILL.
//  - FILL: wr_en=1, wr_addr=row_base+col, wr_data=latched index. A write completes on a cycle
//    with wr_en&wr_ready; only then pix_count++ and col advances. While wr_ready==0, wr_en,
//    wr_addr, wr_data hold stable.
//    After completing col==x_end-1: col<=rect_x, row++, row_base+=H_RES; if row==y_end-1 the
//    rectangle is finished -> DONE (wr_en low from next cycle).
//  - DONE: done=1 for exactly one cycle, busy<=0, return IDLE; new start accepted next cycle.
//  - Latency: start at cycle N -> first wr_en at N+2; WxH rect with wr_ready=1 -> done at
//    N+2+W*H. Empty/offscreen rect -> done at N+2.
//  - wr_addr never exceeds H_RES*V_RES-1; no write ever lands outside the clipped rectangle.
// TESTING
//  1. x=10,y=5,w=3,h=2,idx=0x2A, wr_ready=1 -> addrs 3210,3211,3212,3850,3851,3852, data 0x2A,
//     done at start+8, pix_count=6.
//  2. x=638,y=479,w=8,h=8 -> clipped: writes only 307198,307199; pix_count=2, done pulse.
//  3. w=0 (or x=700) -> zero wr_en cycles, done exactly 2 cycles after start, pix_count=0.
//  4. wr_ready toggled 0/1 every cycle during 4x1 fill -> wr_addr/wr_data stable while low,
//     exactly 4 completed writes, no duplicates or skips.
//  5. start re-pulsed while busy with different coords -> ignored; only first rect written.
//  6. rst asserted after 3 writes of a 5x5 fill -> next cycle wr_en=0,busy=0,done=0,pix_count=0;
//     fresh start afterwards behaves as scenario 1.

Source files
------------

// File: rtl/fb_rect_writer.sv
// Frame RAM port-B rectangle filler: writes one colour index into a clipped rectangle,
// one pixel per accepted write, with stall support via wr_ready.
module fb_rect_writer #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned AW    = 19
) (
  input  logic          procClock,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    rect_x,
  input  logic [8:0]    rect_y,
  input  logic [9:0]    rect_w,
  input  logic [8:0]    rect_h,
  input  logic [7:0]    fill_index,
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic [18:0]   pix_count
);

  localparam logic [10:0]   HResX = 11'(H_RES);
  localparam logic [9:0]    HResC = 10'(H_RES);
  localparam logic [9:0]    VResY = 10'(V_RES);
  localparam logic [8:0]    VResR = 9'(V_RES);
  localparam logic [AW-1:0] HResA = AW'(H_RES);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d, w_q, w_d, col_q, col_d, x_end_q, x_end_d;
  logic [8:0]    y_q, y_d, h_q, h_d, row_q, row_d, y_end_q, y_end_d;
  logic [AW-1:0] row_base_q, row_base_d, wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [18:0]   pix_count_q, pix_count_d;

  logic [10:0]   x_sum;
  logic [9:0]    y_sum;
  logic [9:0]    x_clip;
  logic [8:0]    y_clip;
  logic          empty;
  logic [AW-1:0] y_base;
  logic          write_ok;

  always_comb begin
    x_sum    = {1'b0, x_q} + {1'b0, w_q};
    y_sum    = {1'b0, y_q} + {1'b0, h_q};
    x_clip   = (x_sum > HResX) ? HResC : x_sum[9:0];
    y_clip   = (y_sum > VResY) ? VResR : y_sum[8:0];
    empty    = (w_q == 10'd0) || (h_q == 9'd0) || (x_q >= HResC) || (y_q >= VResR);
    // y*640 as y*512 + y*128
    y_base   = (AW'(y_q) << 9) + (AW'(y_q) << 7);
    write_ok = wr_en_q & wr_ready;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    row_base_d  = row_base_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pix_count_d = pix_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d         = rect_x;
          y_d         = rect_y;
          w_d         = rect_w;
          h_d         = rect_h;
          wr_data_d   = fill_index;
          pix_count_d = 19'd0;
          busy_d      = 1'b1;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        x_end_d = x_clip;
        y_end_d = y_clip;
        if (empty) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          row_base_d = y_base;
          col_d      = x_q;
          row_d      = y_q;
          wr_addr_d  = y_base + AW'(x_q);
          wr_en_d    = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        // Outputs hold while the RAM stalls; advance only on a completed write.
        if (write_ok) begin
          pix_count_d = pix_count_q + 19'd1;
          if (col_q == x_end_q - 10'd1) begin
            if (row_q == y_end_q - 9'd1) begin
              wr_en_d = 1'b0;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              col_d      = x_q;
              row_d      = row_q + 9'd1;
              row_base_d = row_base_q + HResA;
              wr_addr_d  = row_base_q + HResA + AW'(x_q);
            end
          end else begin
            col_d     = col_q + 10'd1;
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge procClock) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      row_base_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      row_base_q  <= row_base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: a reference model queues expected writes per
// rectangle and a negedge monitor pops and compares every completed write.
module tb_fb_rect_writer;

  logic        procClock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  rect_x = '0;
  logic [8:0]  rect_y = '0;
  logic [9:0]  rect_w = '0;
  logic [8:0]  rect_h = '0;
  logic [7:0]  fill_index = '0;
  logic        wr_ready = 1'b1;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic [18:0] pix_count;

  fb_rect_writer #(.H_RES(640), .V_RES(480), .AW(19)) dut (
    .procClock  (procClock),
    .rst        (rst),
    .start      (start),
    .rect_x     (rect_x),
    .rect_y     (rect_y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .fill_index (fill_index),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .pix_count  (pix_count)
  );

  always #5 procClock = ~procClock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_seen = 0;
  int en_cycles = 0;
  bit ready_toggle = 1'b0;
  int unsigned exp_addr_q[$];
  int unsigned exp_data_q[$];

  always @(posedge procClock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // wr_ready is either held high or toggled every cycle.
  initial begin
    forever begin
      @(posedge procClock);
      #1;
      wr_ready = ready_toggle ? ~wr_ready : 1'b1;
    end
  end

  // Monitor: stability under stall and scoreboard compare of every completed write.
  initial begin
    logic        prev_stall;
    logic [18:0] prev_addr;
    logic [7:0]  prev_data;
    int unsigned ea, ed;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge procClock);
      if (prev_stall && !rst) begin
        check("stall_wr_en", 32'(wr_en), 32'd1);
        check("stall_wr_addr", 32'(wr_addr), 32'(prev_addr));
        check("stall_wr_data", 32'(wr_data), 32'(prev_data));
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (wr_en) en_cycles++;
      if (wr_en && wr_ready) begin
        wr_seen++;
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
        end else begin
          ea = 32'hFFFF_FFFF;
          ed = 32'hFFFF_FFFF;
        end
        check("wr_addr", 32'(wr_addr), ea);
        check("wr_data", 32'(wr_data), ed);
      end
    end
  end

  // Reference model: push clipped rectangle writes in raster order; returns pixel count.
  function automatic int model_push(input int x, y, w, h, input int unsigned idx, input int limit);
    int xe, ye, n;
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 480) ? 480 : y + h;
    n = 0;
    for (int r = y; r < ye; r++) begin
      for (int c = x; c < xe; c++) begin
        if (n < limit) begin
          exp_addr_q.push_back(r * 640 + c);
          exp_data_q.push_back(idx);
        end
        n++;
      end
    end
    return n;
  endfunction

  task automatic run_rect(input string nm, input int x, y, w, h, input logic [7:0] idx,
                          input bit toggle, input bit repulse);
    int npix, st_cyc, done_cyc, en0, seen0;
    bit got_done;
    npix = model_push(x, y, w, h, 32'(idx), 1 << 20);
    @(posedge procClock);
    #2;
    ready_toggle = toggle;
    rect_x = 10'(x);
    rect_y = 9'(y);
    rect_w = 10'(w);
    rect_h = 9'(h);
    fill_index = idx;
    start = 1'b1;
    st_cyc = cyc;
    en0 = en_cycles;
    seen0 = wr_seen;
    got_done = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge procClock);
      #1;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        @(posedge procClock);
        #2;
        if (repulse && i == 2) begin
          start = 1'b1;
          rect_x = 10'd0;
          rect_y = 9'd0;
          rect_w = 10'd20;
          rect_h = 9'd20;
          fill_index = 8'hEE;
        end else begin
          start = 1'b0;
        end
      end
    end
    check({nm, "_done_seen"}, 32'(got_done), 32'd1);
    if (!toggle) begin
      check({nm, "_done_latency"}, 32'(done_cyc - st_cyc), 32'(2 + npix));
      check({nm, "_en_cycles"}, 32'(en_cycles - en0), 32'(npix));
    end
    check({nm, "_writes"}, 32'(wr_seen - seen0), 32'(npix));
    check({nm, "_pix_count"}, 32'(pix_count), 32'(npix));
    check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
    check({nm, "_queue_left"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge procClock);
    #2;
    start = 1'b0;
    ready_toggle = 1'b0;
    @(negedge procClock);
    #1;
    check({nm, "_done_pulse_end"}, 32'(done), 32'd0);
    check({nm, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen0, dummy;
    repeat (3) @(posedge procClock);
    @(negedge procClock);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pix_count", 32'(pix_count), 32'd0);
    @(posedge procClock);
    #2;
    rst = 1'b0;

    run_rect("s1", 10, 5, 3, 2, 8'h2A, 1'b0, 1'b0);
    run_rect("s2_clip", 638, 479, 8, 8, 8'h11, 1'b0, 1'b0);
    run_rect("s3_w0", 5, 5, 0, 4, 8'h33, 1'b0, 1'b0);
    run_rect("s3_x700", 700, 10, 4, 4, 8'h34, 1'b0, 1'b0);
    run_rect("s3_h0", 0, 0, 7, 0, 8'h35, 1'b0, 1'b0);
    run_rect("s4_stall", 20, 30, 4, 1, 8'h44, 1'b1, 1'b0);
    run_rect("s5_repulse", 40, 60, 4, 2, 8'h55, 1'b0, 1'b1);

    // Reset during the third write of a 5x5 fill.
    dummy = model_push(100, 50, 5, 5, 32'h66, 3);
    @(posedge procClock);
    #2;
    rect_x = 10'd100;
    rect_y = 9'd50;
    rect_w = 10'd5;
    rect_h = 9'd5;
    fill_index = 8'h66;
    start = 1'b1;
    seen0 = wr_seen;
    for (int i = 0; i < 50; i++) begin
      @(posedge procClock);
      #2;
      start = 1'b0;
      if (wr_seen - seen0 >= 2) break;
    end
    rst = 1'b1;
    @(posedge procClock);
    #2;
    @(negedge procClock);
    #1;
    check("s6_rst_wr_en", 32'(wr_en), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_pix_count", 32'(pix_count), 32'd0);
    @(posedge procClock);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge procClock);
    #2;
    check("s6_writes_before_rst", 32'(wr_seen - seen0), 32'd3);
    check("s6_queue_left", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    run_rect("s6_after", 10, 5, 3, 2, 8'h2A, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
